// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 constants, FSM states and unpacked operand type
package fp32_pkg;

  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;
  localparam int FP32_MANT_W  = 23;
  localparam int PROD_W       = 48;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
  } fp32_unpacked_t;

  // Mantissa carries the implicit leading one; zero exponents are caught by the caller.
  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] v);
    fp32_unpacked_t u;
    u.sign = v[31];
    u.exp  = v[30:23];
    u.mant = {1'b1, v[FP32_MANT_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// rtl/fmul_round_pack.sv - normalise, round-to-nearest-even and pack a 48-bit product
module fmul_round_pack
  import fp32_pkg::*;
(
  input  logic [PROD_W-1:0] product_i,
  input  logic [9:0]        exp_sum_i,
  input  logic              sign_i,
  input  logic              zero_flag_i,
  output logic [31:0]       result_o,
  output logic              error_o
);

  logic [22:0]       mant;
  logic              g, r, s, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n, exp_r;

  always_comb begin
    mant     = '0;
    g        = 1'b0;
    r        = 1'b0;
    s        = 1'b0;
    exp_n    = $signed(exp_sum_i);
    result_o = '0;
    error_o  = 1'b0;
    if (product_i[47]) begin
      mant  = product_i[46:24];
      g     = product_i[23];
      r     = product_i[22];
      s     = |product_i[21:0];
      exp_n = $signed(exp_sum_i) + 10'sd1;
    end else begin
      mant  = product_i[45:23];
      g     = product_i[22];
      r     = product_i[21];
      s     = |product_i[20:0];
    end
    round_up = g & (r | s | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    // A rounding carry leaves mant_r[22:0] at zero, which is the renormalised fraction.
    exp_r    = exp_n + $signed({9'd0, mant_r[23]});

    if (zero_flag_i) begin
      result_o = {sign_i, 31'h0};
    end else if (exp_r >= $signed(10'(FP32_EXP_MAX))) begin
      result_o = {sign_i, 8'hFF, 23'h0};
      error_o  = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      result_o = {sign_i, 31'h0};
      error_o  = 1'b1;
    end else begin
      result_o = {sign_i, exp_r[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/fmul_seq_ctrl.sv
// rtl/fmul_seq_ctrl.sv - sequential binary32 multiply controller with shift-add mantissa core
module fmul_seq_ctrl
  import fp32_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_error,
  output logic        busy
);

  localparam int MUL_CYCLES = 24 / BITS_PER_CYCLE;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [9:0]          exp_sum_q, exp_sum_d;
  logic [23:0]         mcand_q, mcand_d;
  logic [23:0]         mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                zero_q, zero_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         result_q, result_d;
  logic                error_q, error_d;

  fp32_unpacked_t      ua, ub;
  logic [PROD_W-1:0]   partial;
  logic [4:0]          shamt;
  logic [31:0]         rp_result;
  logic                rp_error;

  assign ua = fp32_unpack(in_a);
  assign ub = fp32_unpack(in_b);

  fmul_round_pack u_round_pack (
    .product_i   (acc_q),
    .exp_sum_i   (exp_sum_q),
    .sign_i      (sign_q),
    .zero_flag_i (zero_q),
    .result_o    (rp_result),
    .error_o     (rp_error)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_sum_d   = exp_sum_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    error_d     = error_q;
    partial     = PROD_W'(mcand_q) * PROD_W'(mplier_q[BITS_PER_CYCLE-1:0]);
    shamt       = 5'(cnt_q * 5'(BITS_PER_CYCLE));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = ua.sign ^ ub.sign;
          exp_sum_d = {2'b00, ua.exp} + {2'b00, ub.exp} - 10'(FP32_BIAS);
          mcand_d   = ua.mant;
          mplier_d  = ub.mant;
          acc_d     = '0;
          cnt_d     = '0;
          zero_d    = (ua.exp == 8'd0) || (ub.exp == 8'd0);
          state_d   = zero_d ? NORM : MUL;
        end
      end
      MUL: begin
        acc_d    = acc_q + (partial << shamt);
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_CYCLES - 1)) state_d = NORM;
      end
      NORM: begin
        result_d = rp_result;
        error_d  = rp_error;
        state_d  = DONE;
      end
      DONE: begin
        // Valid rises one cycle after entry so the handshake only ever sees registered results.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_sum_q   <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_sum_q   <= exp_sum_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      error_q     <= error_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_error  = error_q;

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// tb/tb_fmul_seq_ctrl.sv - self-checking bench for fmul_seq_ctrl at 1 and 4 bits per cycle
module tb_fmul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_error1, busy1;
  logic [31:0] out_result1;
  logic        in_ready4, out_valid4, out_error4, busy4;
  logic [31:0] out_result4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fmul_seq_ctrl u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(out_result1), .out_error(out_error1), .busy(busy1)
  );

  fmul_seq_ctrl #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .out_error(out_error4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea, eb, e, sh;
    longint unsigned   ma, mb, prod, keep, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    ma   = longint'({1'b1, a[22:0]});
    mb   = longint'({1'b1, b[22:0]});
    prod = ma * mb;
    e    = ea + eb - 127;
    if (prod >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    keep = prod >> sh;
    rem  = prod & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin keep = 64'd1 << 23; e = e + 1; end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b1, s, 31'h0};
    return {1'b0, s, e[7:0], keep[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic e1, output int l1,
                       output logic [31:0] r4, output logic e4, output int l4);
    l1 = 0; l4 = 0; r1 = '0; r4 = '0; e1 = 1'b0; e4 = 1'b0;
    @(negedge clk);
    check("in_ready_before_accept", {in_ready4, in_ready1}, 32'h3);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    for (int k = 1; k <= 60 && (l1 == 0 || l4 == 0); k++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && l1 == 0) begin l1 = k; r1 = out_result1; e1 = out_error1; end
      if (out_valid4 && l4 == 0) begin l4 = k; r4 = out_result4; e4 = out_error4; end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_and_check(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_err);
    logic [31:0] r1, r4;
    logic        e1, e4;
    int          l1, l4, exp_l1, exp_l4;
    bit          zero_path;
    zero_path = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
    exp_l1 = zero_path ? 2 : 24 + 2;
    exp_l4 = zero_path ? 2 : 6 + 2;
    do_op(a, b, r1, e1, l1, r4, e4, l4);
    check($sformatf("result_b1 %h*%h", a, b), r1, exp_res);
    check($sformatf("error_b1 %h*%h", a, b), 32'(e1), 32'(exp_err));
    check($sformatf("latency_b1 %h*%h", a, b), 32'(l1), 32'(exp_l1));
    check($sformatf("result_b4 %h*%h", a, b), r4, exp_res);
    check($sformatf("error_b4 %h*%h", a, b), 32'(e4), 32'(exp_err));
    check($sformatf("latency_b4 %h*%h", a, b), 32'(l4), 32'(exp_l4));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 10));
      3:       e = 8'($urandom_range(245, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  vec_t vecs[7];

  initial begin
    logic [32:0] m;
    logic [31:0] a, b;
    int          waited, seen;

    vecs[0] = '{a: 32'h3FC00000, b: 32'h40000000, res: 32'h40400000, err: 1'b0};
    vecs[1] = '{a: 32'hBF800000, b: 32'h3F800000, res: 32'hBF800000, err: 1'b0};
    vecs[2] = '{a: 32'h00000000, b: 32'hC0490FDB, res: 32'h80000000, err: 1'b0};
    vecs[3] = '{a: 32'h3F800001, b: 32'h3F800001, res: 32'h3F800002, err: 1'b0};
    vecs[4] = '{a: 32'h3FFFFFFF, b: 32'h3FFFFFFF, res: 32'h407FFFFE, err: 1'b0};
    vecs[5] = '{a: 32'h7F000000, b: 32'h7F000000, res: 32'h7F800000, err: 1'b1};
    vecs[6] = '{a: 32'h00800000, b: 32'h00800000, res: 32'h00000000, err: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready1), 32'd1);
    check("reset_out_valid", 32'(out_valid1), 32'd0);
    check("reset_out_result", out_result1, 32'h0);
    check("reset_out_error", 32'(out_error1), 32'd0);
    check("reset_busy", 32'(busy1), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) run_and_check(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);

    // Backpressure: hold the result in DONE while in_valid pulses are offered.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waited = 0;
    while (!out_valid1 && waited < 60) begin @(posedge clk); #1 waited++; end
    check("bp_valid_reached", 32'(out_valid1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; in_a = $urandom; in_b = $urandom;
      @(posedge clk);
      #1;
      check("bp_out_valid_held", 32'(out_valid1), 32'd1);
      check("bp_out_result_held", out_result1, 32'h40400000);
      check("bp_in_ready_low", 32'(in_ready1), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid_drop", 32'(out_valid1), 32'd0);
    check("bp_release_in_ready", 32'(in_ready1), 32'd1);
    in_valid = 1'b1; in_a = 32'hBF800000; in_b = 32'h3F800000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_accepted", 32'(busy1), 32'd1);
    waited = 0;
    while (!(out_valid1 && out_valid4) && waited < 60) begin @(posedge clk); #1 waited++; end
    check("bp_next_result", out_result1, 32'hBF800000);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset during MUL abandons the operation.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy1), 32'd0);
    check("rst_mid_out_valid", {31'd0, out_valid1}, 32'd0);
    check("rst_mid_out_valid_b4", {busy4, out_valid4}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", 32'(in_ready1), 32'd1);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (out_valid1 || out_valid4) seen++;
    end
    check("rst_no_result", 32'(seen), 32'd0);
    run_and_check(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      m = model(a, b);
      run_and_check(a, b, m[31:0], m[32]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
